// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select arbiter and its round-robin picker.
package mux_sel_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_I0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_I1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_I2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_I3 = 2'd3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  function automatic logic [NUM_SRC-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    sel_to_onehot      = '0;
    sel_to_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request starting after index `last`,
// so `last` itself is checked at the lowest priority.
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    any   = |req;
    win   = SEL_I0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      // Two-bit truncation wraps the search order modulo four.
      idx = SEL_W'(32'(last) + k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select lines {s1,s0}.
// Optional hold-timeout watchdog enabled by defining MUX_SEL_TIMEOUT_EN.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               done,
  output logic [NUM_SRC-1:0] gnt,
  output logic               valid,
  output logic               s1,
  output logic               s0,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_win;
  logic               user_rel;
  logic               force_rel;
  logic               release_now;
  logic               new_grant;

  // The owner is always the most recent grant, so one picker seeded with
  // `last` serves both the IDLE and the release arbitration paths.
  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign user_rel    = done || !req[owner_q];
  assign release_now = (state_q == GRANT) && (user_rel || force_rel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (pick_any) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    if (new_grant) begin
      owner_d = pick_win;
      last_d  = pick_win;
      gnt_d   = sel_to_onehot(pick_win);
      valid_d = 1'b1;
      sel_d   = pick_win;
    end else if (state_d == IDLE) begin
      gnt_d   = '0;
      valid_d = 1'b0;
      sel_d   = SEL_I0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= SEL_I0;
      last_q  <= SEL_I3;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      sel_q   <= SEL_I0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];

`ifdef MUX_SEL_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Forced release only when nothing else releases the owner this edge.
  assign force_rel = (state_q == GRANT) && !user_rel && (cnt_q == HOLD_LAST);
  assign timeout_d = force_rel;

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant) begin
      cnt_d = '0;
    end else if ((state_q == GRANT) && !release_now) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed vector table, timeout and
// reset sequences, then random traffic against a behavioural model.
module tb_mux_sel_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef MUX_SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       valid;
  logic       s1;
  logic       s0;
  logic       timeout;

  mux_sel_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .valid   (valid),
    .s1      (s1),
    .s0      (s0),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: owner index (-1 = idle), last grant, cycles held so far.
  int m_owner = -1;
  int m_last  = 3;
  int m_held  = 0;
  bit m_to    = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[$];

  function automatic int pick(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++) begin
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    bit rel;
    bit forced;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
      end
    end else begin
      rel    = d || !r[m_owner];
      forced = TO_EN && !rel && (m_held == int'(HOLD));
      if (rel || forced) begin
        m_to = forced;
        w    = pick(r, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    if (m_owner >= 0) chk({tag, ".sel"}, 32'({s1, s0}), 32'(m_owner));
  endtask

  // Drive inputs, let one rising edge pass, advance the model, then sample.
  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    chk_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;

    tbl.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'b00});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'b01});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 2'b10});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 2'b11});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'b00});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00});
    tbl.push_back('{4'b1010, 1'b0, 4'b0010, 1'b1, 2'b01});
    tbl.push_back('{4'b1010, 1'b1, 4'b1000, 1'b1, 2'b11});
    tbl.push_back('{4'b1010, 1'b1, 4'b0010, 1'b1, 2'b01});
    tbl.push_back('{4'b1010, 1'b1, 4'b1000, 1'b1, 2'b11});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00});
    tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 2'b10});
    tbl.push_back('{4'b0101, 1'b1, 4'b0001, 1'b1, 2'b00});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00});
    tbl.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1, 2'b01});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00});

    repeat (3) @(posedge clk);
    #1;
    chk("reset.gnt", 32'(gnt), 32'h0);
    chk("reset.valid", 32'(valid), 32'h0);
    chk("reset.sel", 32'({s1, s0}), 32'h0);
    chk("reset.timeout", 32'(timeout), 32'h0);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.gnt_tbl", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d.valid_tbl", i), 32'(valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d.sel_tbl", i), 32'({s1, s0}), 32'(tbl[i].sel));
      chk($sformatf("vec%0d.to_tbl", i), 32'(timeout), 32'h0);
    end

    // Hold timeout: last=1, so req 0011 grants i0 which then never releases.
    for (int c = 1; c <= 4; c++) begin
      step(4'b0011, 1'b0, $sformatf("hold%0d", c));
      chk($sformatf("hold%0d.gnt_exp", c), 32'(gnt), 32'h1);
    end
    step(4'b0011, 1'b0, "hold5");
    chk("hold5.gnt_exp", 32'(gnt), TO_EN ? 32'h2 : 32'h1);
    chk("hold5.to_exp", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
    step(4'b0011, 1'b0, "hold6");
    chk("hold6.to_exp", 32'(timeout), 32'h0);
    step(4'b0000, 1'b1, "hold_end");

    // Asynchronous reset in the middle of a grant.
    step(4'b1111, 1'b0, "pre_rst");
    step(4'b1111, 1'b1, "pre_rst2");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.gnt", 32'(gnt), 32'h0);
    chk("midrst.valid", 32'(valid), 32'h0);
    chk("midrst.sel", 32'({s1, s0}), 32'h0);
    chk("midrst.timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_to    = 1'b0;
    step(4'b1111, 1'b0, "post_rst");
    chk("post_rst.gnt_exp", 32'(gnt), 32'h1);
    chk("post_rst.sel_exp", 32'({s1, s0}), 32'h0);

    // Random traffic; requests change only sometimes so holds can run long.
    begin
      logic [3:0] r;
      r = 4'($urandom);
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(3) == 0) r = 4'($urandom);
        step(r, ($urandom_range(4) == 0), $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
